demux_stream: RTL and testbench

//  - 1-to-2 demultiplexer with ready/valid handshake. Steers one WIDTH-bit source stream to out1 or out2 per transaction.
//  - Complement of the datapath Mux, used where one producer result feeds one of two consumers.
//  - Example: ALU result routed to register-file writeback or store buffer.
//  - One-entry holding register per output gives one cycle of latency and independent back-pressure per destination.

---
 rtl/demux_stream_pkg.sv | 23 ++
 rtl/demux_stream_slot.sv | 72 +++++++
 rtl/demux_stream.sv | 92 +++++++++
 tb/tb_demux_stream.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_stream_pkg.sv
// Shared definitions for the demux_stream block.
//
// Contents:
//   DATA_WIDTH        default width of the data path
//   CNT_WIDTH_DEFAULT default width of the per-output delivery counters
//   SEL_OUT1/SEL_OUT2 values of the select input that address each output
//   slot_state_e      state encoding of a one-entry output slot

package demux_stream_pkg;

  localparam int unsigned DATA_WIDTH        = 32;
  localparam int unsigned CNT_WIDTH_DEFAULT = 16;

  localparam logic SEL_OUT1 = 1'b0;
  localparam logic SEL_OUT2 = 1'b1;

  // EMPTY: nothing held, valid low. FULL: one undelivered transaction, valid high.
  typedef enum logic {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/demux_stream_slot.sv
// One-entry output slot of the demux_stream block.
//
// Holds a single transaction for one destination, presents it with a valid
// flag until the destination takes it, and counts delivered transactions.
//
// Ports:
//   clk_i    clock, all state changes on the rising edge
//   reset_i  synchronous active-high reset; discards held data, clears counter
//   load_i   write data_i into the slot on this edge
//   data_i   transaction data to load
//   ready_i  destination takes the held transaction on this edge
//   valid_o  slot holds an undelivered transaction
//   data_o   held transaction data
//   count_o  number of transactions delivered (wraps silently)

module demux_stream_slot
  import demux_stream_pkg::*;
#(
  parameter int unsigned Width    = DATA_WIDTH,
  parameter int unsigned CntWidth = CNT_WIDTH_DEFAULT
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                load_i,
  input  logic [Width-1:0]    data_i,
  input  logic                ready_i,
  output logic                valid_o,
  output logic [Width-1:0]    data_o,
  output logic [CntWidth-1:0] count_o
);

  slot_state_e         state_q;
  logic [Width-1:0]    data_q;
  logic [CntWidth-1:0] count_q;

  // The parent only asserts load_i when the slot is empty or draining this
  // cycle, so a load into a FULL slot always coincides with a delivery.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StEmpty;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      // A delivery is a handshake on a FULL slot; ready while EMPTY is ignored.
      if ((state_q == StFull) && ready_i) begin
        count_q <= count_q + CntWidth'(1);
      end
      case (state_q)
        StEmpty: begin
          if (load_i) begin
            data_q  <= data_i;
            state_q <= StFull;
          end
        end
        StFull: begin
          if (load_i) begin
            // Drain and refill on the same edge: stay FULL with new data.
            data_q <= data_i;
          end else if (ready_i) begin
            state_q <= StEmpty;
          end
        end
        default: state_q <= StEmpty;
      endcase
    end
  end

  assign valid_o = (state_q == StFull);
  assign data_o  = data_q;
  assign count_o = count_q;

endmodule

// File: rtl/demux_stream.sv
// 1-to-2 stream demultiplexer with ready/valid handshake.
//
// Each accepted input transaction is steered by select to one of two
// one-entry output slots (select=0 -> out1, select=1 -> out2). Each slot
// gives one cycle of latency and independent back-pressure, so a stalled
// destination never blocks traffic addressed to the other one.
//
// Ports:
//   clk          clock, rising edge
//   reset        synchronous active-high reset
//   in_data      source data
//   select       destination of the offered transaction
//   in_valid     source offers a transaction
//   in_ready     selected slot can take a transaction this cycle
//   out1/out2    held data for destination 1/2
//   outN_valid   slot N holds an undelivered transaction
//   outN_ready   destination N takes the transaction
//   count1/2     transactions delivered on out1/out2

module demux_stream
  import demux_stream_pkg::*;
#(
  parameter int unsigned WIDTH     = DATA_WIDTH,
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 select,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     out1,
  output logic                 out1_valid,
  input  logic                 out1_ready,
  output logic [WIDTH-1:0]     out2,
  output logic                 out2_valid,
  input  logic                 out2_ready,
  output logic [CNT_WIDTH-1:0] count1,
  output logic [CNT_WIDTH-1:0] count2
);

  logic slot1_free;
  logic slot2_free;
  logic accept;
  logic load1;
  logic load2;

  // A slot can take data if it is empty or its destination drains it on the
  // same edge. Only the addressed slot matters; in_valid is not involved.
  assign slot1_free = ~out1_valid | out1_ready;
  assign slot2_free = ~out2_valid | out2_ready;

  always_comb begin
    in_ready = slot1_free;
    if (select == SEL_OUT2) begin
      in_ready = slot2_free;
    end
  end

  assign accept = in_valid & in_ready;
  assign load1  = accept & (select == SEL_OUT1);
  assign load2  = accept & (select == SEL_OUT2);

  demux_stream_slot #(
    .Width    (WIDTH),
    .CntWidth (CNT_WIDTH)
  ) u_slot1 (
    .clk_i   (clk),
    .reset_i (reset),
    .load_i  (load1),
    .data_i  (in_data),
    .ready_i (out1_ready),
    .valid_o (out1_valid),
    .data_o  (out1),
    .count_o (count1)
  );

  demux_stream_slot #(
    .Width    (WIDTH),
    .CntWidth (CNT_WIDTH)
  ) u_slot2 (
    .clk_i   (clk),
    .reset_i (reset),
    .load_i  (load2),
    .data_i  (in_data),
    .ready_i (out2_ready),
    .valid_o (out2_valid),
    .data_o  (out2),
    .count_o (count2)
  );

endmodule

// File: tb/tb_demux_stream.sv
module tb_demux_stream;

  logic        clk;
  logic        reset;
  logic [31:0] in_data;
  logic        select;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out1;
  logic        out1_valid;
  logic        out1_ready;
  logic [31:0] out2;
  logic        out2_valid;
  logic        out2_ready;
  logic [15:0] count1;
  logic [15:0] count2;

  demux_stream #(
    .WIDTH     (32),
    .CNT_WIDTH (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .select     (select),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out1       (out1),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out2       (out2),
    .out2_valid (out2_valid),
    .out2_ready (out2_ready),
    .count1     (count1),
    .count2     (count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected deliveries per destination, pushed by the driver on accept.
  logic [31:0] q1[$];
  logic [31:0] q2[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: outputs sampled on the falling edge, away from the active edge.
  logic        hold1, hold2;
  logic [31:0] hdat1, hdat2;
  initial begin
    hold1 = 1'b0;
    hold2 = 1'b0;
    hdat1 = '0;
    hdat2 = '0;
  end

  always @(negedge clk) begin
    if (reset) begin
      hold1 <= 1'b0;
      hold2 <= 1'b0;
    end else begin
      if (hold1) begin
        check("out1_valid_stable", {31'd0, out1_valid}, 32'd1);
        check("out1_data_stable", out1, hdat1);
      end
      if (hold2) begin
        check("out2_valid_stable", {31'd0, out2_valid}, 32'd1);
        check("out2_data_stable", out2, hdat2);
      end
      if (out1_valid && out1_ready) begin
        if (q1.size() == 0) check("out1_unexpected", out1, 32'hxxxxxxxx);
        else check("out1_data", out1, q1.pop_front());
      end
      if (out2_valid && out2_ready) begin
        if (q2.size() == 0) check("out2_unexpected", out2, 32'hxxxxxxxx);
        else check("out2_data", out2, q2.pop_front());
      end
      hold1 <= out1_valid & ~out1_ready;
      hold2 <= out2_valid & ~out2_ready;
      hdat1 <= out1;
      hdat2 <= out2;
    end
  end

  // Driver tasks: entered and left at posedge+1.
  task automatic send(input logic [31:0] d, input logic sel);
    int waited;
    in_data  = d;
    select   = sel;
    in_valid = 1'b1;
    waited   = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("send_timeout", {31'd0, in_ready}, 32'd1);
    end else begin
      if (sel) q2.push_back(d);
      else     q1.push_back(d);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    in_data    = '0;
    select     = 1'b0;
    in_valid   = 1'b0;
    out1_ready = 1'b0;
    out2_ready = 1'b0;

    // 1. reset
    idle(2);
    reset = 1'b0;
    @(negedge clk);
    check("rst_out1_valid", {31'd0, out1_valid}, 32'd0);
    check("rst_out2_valid", {31'd0, out2_valid}, 32'd0);
    check("rst_count1", {16'd0, count1}, 32'd0);
    check("rst_count2", {16'd0, count2}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out1", out1, 32'd0);
    @(posedge clk);
    #1;

    // 2. single transfer to out1
    out1_ready = 1'b1;
    send(32'h0000_0001, 1'b0);
    @(negedge clk);
    check("t2_out1", out1, 32'h1);
    check("t2_out1_valid", {31'd0, out1_valid}, 32'd1);
    check("t2_out2_valid", {31'd0, out2_valid}, 32'd0);
    @(negedge clk);
    check("t2_count1", {16'd0, count1}, 32'd1);
    check("t2_out1_empty", {31'd0, out1_valid}, 32'd0);
    @(posedge clk);
    #1;

    // 3. stalled out2 blocks only select=1
    send(32'hA5A5_A5A5, 1'b1);
    in_data  = 32'h5A5A_5A5A;
    select   = 1'b1;
    in_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("t3_in_ready_sel1", {31'd0, in_ready}, 32'd0);
      check("t3_out2_held", out2, 32'hA5A5_A5A5);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    select   = 1'b0;
    #1;
    check("t3_in_ready_sel0", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    send(32'h0000_0007, 1'b0);
    idle(2);
    check("t3_count1", {16'd0, count1}, 32'd2);
    check("t3_out2_still", out2, 32'hA5A5_A5A5);
    out2_ready = 1'b1;
    send(32'h5A5A_5A5A, 1'b1);
    idle(2);
    check("t3_count2", {16'd0, count2}, 32'd2);

    // 4. drain and load on the same edge
    out1_ready = 1'b0;
    send(32'h0000_0008, 1'b0);
    out1_ready = 1'b1;
    send(32'h0000_0002, 1'b0);
    @(negedge clk);
    check("t4_out1_valid", {31'd0, out1_valid}, 32'd1);
    check("t4_out1", out1, 32'h2);
    check("t4_count1_mid", {16'd0, count1}, 32'd3);
    @(negedge clk);
    check("t4_count1", {16'd0, count1}, 32'd4);
    check("t4_out1_empty", {31'd0, out1_valid}, 32'd0);
    @(posedge clk);
    #1;

    // 5. count2 wrap: 2 already delivered, 65533 more reach 16'hFFFF
    for (int i = 0; i < 65533; i++) begin
      send(32'h1000_0000 + 32'(i), 1'b1);
    end
    idle(3);
    check("t5_count2_max", {16'd0, count2}, 32'h0000_FFFF);
    send(32'hDEAD_BEEF, 1'b1);
    idle(2);
    check("t5_count2_wrap", {16'd0, count2}, 32'd0);
    check("t5_q2_drained", 32'(q2.size()), 32'd0);

    // 6. reset with both slots full
    out1_ready = 1'b0;
    out2_ready = 1'b0;
    send(32'h0000_0011, 1'b0);
    send(32'h0000_0022, 1'b1);
    @(negedge clk);
    check("t6_full1", {31'd0, out1_valid}, 32'd1);
    check("t6_full2", {31'd0, out2_valid}, 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    q1.delete();
    q2.delete();
    @(negedge clk);
    check("t6_valid1", {31'd0, out1_valid}, 32'd0);
    check("t6_valid2", {31'd0, out2_valid}, 32'd0);
    check("t6_count1", {16'd0, count1}, 32'd0);
    check("t6_count2", {16'd0, count2}, 32'd0);
    check("t6_out1", out1, 32'd0);
    check("t6_out2", out2, 32'd0);
    @(posedge clk);
    #1;
    // Ready on empty slots must not deliver or count.
    out1_ready = 1'b1;
    out2_ready = 1'b1;
    idle(3);
    check("t6_count1_idle", {16'd0, count1}, 32'd0);
    check("t6_count2_idle", {16'd0, count2}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
